msx_slot_master: RTL and testbench
==================================

MSX_SLOT_MASTER -- requirements
Module: msx_slot_master

Interface
REQ-001 SHALL have parameter T_CLKS, default 12: clk cycles per Z80 T-state (42.95MHz / 3.58MHz).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 4096: maximum extra-wait clocks, used only when the timeout feature is compiled in.
REQ-003 SHALL have port clk, input, 1 bit: single clock domain (clk42m).
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have internal bus ports bus_address in 8, bus_ioreq in 1, bus_write in 1, bus_valid in 1, bus_ready out 1, bus_wdata in 8, bus_rdata out 8, bus_rdata_en out 1.
REQ-006 SHALL have slot outputs p_slot_address 8, p_slot_ioreq_n 1, p_slot_rd_n 1, p_slot_wr_n 1, p_slot_data_out 8, p_slot_data_oe 1 (1 = drive data bus).
REQ-007 SHALL have slot inputs p_slot_data_in 8 and p_slot_wait 1 (active-high, asynchronous to clk).
REQ-008 SHALL have port bus_timeout, output, 1 bit: one-cycle timeout pulse.

Function
REQ-009 SHALL implement states IDLE, T1, T2, TW, T3; each non-IDLE state SHALL last exactly T_CLKS clocks, timed by a phase counter 0..T_CLKS-1.
REQ-010 SHALL drive bus_ready=1 only in IDLE.
REQ-011 SHALL accept a request on a clock edge with bus_valid & bus_ready & bus_ioreq, latch address, write and wdata, and enter T1.
REQ-012 SHALL ignore bus_valid with bus_ioreq=0: no strobe activity, and bus_ready stays 1.
REQ-013 SHALL drive p_slot_address from the latched address from T1 through T3, and SHALL hold it unchanged in IDLE.
REQ-014 SHALL, on a write, drive p_slot_data_oe=1 and p_slot_data_out=wdata from T1 through T3.
REQ-015 SHALL assert p_slot_ioreq_n=0 and p_slot_rd_n=0 (read) or p_slot_wr_n=0 (write) from the first clock of T2 through the last clock of T3.
REQ-016 SHALL pass p_slot_wait through a 2-flop synchroniser; at the last clock of TW, a synchronised wait of 1 SHALL repeat TW, and 0 SHALL advance to T3. One TW always occurs (the Z80 automatic I/O wait).
REQ-017 SHALL, on a read, sample p_slot_data_in at the last clock of T3 into bus_rdata, and bus_rdata SHALL hold that value until the next read completes.
REQ-018 SHALL, on every transition into IDLE, deassert all strobes, set p_slot_data_oe=0 and bus_ready=1, and, for reads only, set bus_rdata_en=1 for exactly that one cycle.
REQ-019 SHALL have a minimum accept-to-IDLE latency of 4*T_CLKS clocks, plus T_CLKS per extra TW.
REQ-020 SHALL never let a request presented while busy alter the cycle in progress.

Reset
REQ-021 SHALL, on reset_n=0 (immediately, including mid-cycle), enter IDLE and set p_slot_ioreq_n, p_slot_rd_n and p_slot_wr_n to 1; p_slot_data_oe, bus_rdata_en and bus_timeout to 0; p_slot_address, p_slot_data_out and bus_rdata to 0; bus_ready to 1; and clear the synchroniser and counters.

Configuration
REQ-022 SHALL support macro MSX_SLOT_MASTER_WAIT_TIMEOUT_EN.
REQ-023 SHALL, when the macro is defined, count clocks spent in repeated TW; on reaching TIMEOUT_CLKS it SHALL force T3, return bus_rdata=8'hFF for reads, and pulse bus_timeout for one cycle together with the IDLE entry.
REQ-024 SHALL, when the macro is undefined, wait indefinitely and tie bus_timeout to 0.

Structure
REQ-025 SHALL place the state encoding localparams and the default T_CLKS constant in shared package msx_bus_pkg.
REQ-026 SHALL implement the 2-flop synchroniser as sub-module msx_slot_master_sync; everything else SHALL be flat.

Verification (T_CLKS=12)
REQ-027 SHALL verify this write: address 0x99, data 0x8F -> bus_ready low 48 clocks, p_slot_data_oe high 48 clocks, p_slot_wr_n/p_slot_ioreq_n low 36 clocks, p_slot_address 0x99, no bus_rdata_en.
REQ-028 SHALL verify this read: address 0x98, p_slot_data_in=0x5A -> p_slot_rd_n low 36 clocks, bus_rdata_en pulses 48 clocks after accept, bus_rdata=0x5A.
REQ-029 SHALL verify this wait: p_slot_wait held high across the first TW and released mid second TW -> exactly one extra TW, 60-clock cycle, read data still correct.
REQ-030 SHALL verify this ignored request: bus_valid=1, bus_ioreq=0 -> no strobe change, bus_ready stays 1, no bus_rdata_en.
REQ-031 SHALL verify reset mid-write: reset_n pulsed low during T2 -> strobes high and oe low asynchronously, then a following read completes normally in 48 clocks.
REQ-032 SHALL verify this timeout, with the macro defined and TIMEOUT_CLKS=64: p_slot_wait stuck high during a read -> completion with bus_rdata=0xFF, bus_timeout and bus_rdata_en pulsing together.

Source files
------------

// File: rtl/msx_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msx_bus_pkg                                                   |
// | Purpose  : Shared constants for the MSX slot bus master: Z80 I/O cycle   |
// |            state encoding and the default clk-per-T-state ratio.         |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package msx_bus_pkg;

  // 42.95 MHz system clock / 3.58 MHz Z80 clock
  localparam int unsigned c_t_clks_default = 12;

  localparam int unsigned c_state_w = 3;

  localparam logic [c_state_w-1:0] c_st_idle = 3'd0;
  localparam logic [c_state_w-1:0] c_st_t1   = 3'd1;
  localparam logic [c_state_w-1:0] c_st_t2   = 3'd2;
  localparam logic [c_state_w-1:0] c_st_tw   = 3'd3;
  localparam logic [c_state_w-1:0] c_st_t3   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/msx_slot_master_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msx_slot_master_sync                                          |
// | Purpose  : Two-flop synchroniser for the asynchronous slot WAIT line.    |
// | Ports    : clk      - system clock                                      |
// |            reset_n  - asynchronous active-low reset                     |
// |            d        - asynchronous input                                |
// |            q        - synchronised output (2 clk latency)               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module msx_slot_master_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/msx_slot_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : msx_slot_master                                               |
// | Purpose  : Bridges the internal request bus onto the MSX cartridge slot  |
// |            as Z80-style I/O cycles (T1, T2, TW..., T3), each T-state    |
// |            lasting T_CLKS system clocks.                                |
// | Ports    : clk, reset_n            - clock, async active-low reset      |
// |            bus_*                   - internal request/response bus      |
// |            p_slot_*                - slot address/strobes/data/wait     |
// |            bus_timeout             - one-cycle WAIT timeout pulse       |
// | Options  : MSX_SLOT_MASTER_WAIT_TIMEOUT_EN - bound WAIT extension to    |
// |            TIMEOUT_CLKS clocks; reads that time out return 8'hFF.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module msx_slot_master
  import msx_bus_pkg::*;
#(
  parameter int unsigned T_CLKS       = c_t_clks_default,
  parameter int unsigned TIMEOUT_CLKS = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  // internal bus
  input  logic [7:0] bus_address,
  input  logic       bus_ioreq,
  input  logic       bus_write,
  input  logic       bus_valid,
  output logic       bus_ready,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_rdata_en,
  output logic       bus_timeout,
  // slot
  output logic [7:0] p_slot_address,
  output logic       p_slot_ioreq_n,
  output logic       p_slot_rd_n,
  output logic       p_slot_wr_n,
  output logic [7:0] p_slot_data_out,
  output logic       p_slot_data_oe,
  input  logic [7:0] p_slot_data_in,
  input  logic       p_slot_wait
);

  localparam int unsigned PH_W = (T_CLKS > 1) ? $clog2(T_CLKS) : 1;
  localparam logic [PH_W-1:0] c_ph_last = PH_W'(T_CLKS - 1);

  logic [c_state_w-1:0] state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 write_q, write_d;
  logic                 rdata_en_q, rdata_en_d;

  logic wait_s;
  logic phase_last;
  logic accept;
  logic cycle_end;   // last clock of T3: next edge enters IDLE
  logic tmo_hit;     // WAIT extension exhausted this clock
  logic tmo_flag;    // current cycle was cut short by the timeout

  msx_slot_master_sync u_wait_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (p_slot_wait),
    .q       (wait_s)
  );

  assign phase_last = (phase_q == c_ph_last);
  assign accept     = (state_q == c_st_idle) && bus_valid && bus_ioreq;
  assign cycle_end  = (state_q == c_st_t3) && phase_last;

`ifdef MSX_SLOT_MASTER_WAIT_TIMEOUT_EN
  localparam int unsigned TW_W = $clog2(TIMEOUT_CLKS + 1);

  logic [TW_W-1:0] wcnt_q, wcnt_d;
  logic            extra_q, extra_d;   // inside a repeated (WAIT-extended) TW
  logic            tmo_q, tmo_d;
  logic            timeout_q, timeout_d;

  assign tmo_hit  = (state_q == c_st_tw) && extra_q &&
                    (wcnt_q == TW_W'(TIMEOUT_CLKS - 1));
  assign tmo_flag = tmo_q;

  always_comb begin
    wcnt_d    = wcnt_q;
    extra_d   = extra_q;
    tmo_d     = tmo_q;
    timeout_d = cycle_end && tmo_q;
    if (accept) begin
      wcnt_d  = '0;
      extra_d = 1'b0;
      tmo_d   = 1'b0;
    end else if (state_q == c_st_tw) begin
      if (extra_q) wcnt_d = wcnt_q + TW_W'(1);
      if (tmo_hit) tmo_d = 1'b1;
      else if (phase_last && wait_s) extra_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q    <= '0;
      extra_q   <= 1'b0;
      tmo_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      extra_q   <= extra_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CLKS == 0);
  assign tmo_hit     = 1'b0;
  assign tmo_flag    = 1'b0;
  assign bus_timeout = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_st_idle;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (state_q == c_st_idle) begin
      phase_d = '0;
      if (accept) state_d = c_st_t1;
    end else begin
      phase_d = phase_last ? '0 : phase_q + PH_W'(1);
      if (tmo_hit) begin
        // abandon the WAIT extension; T3 still runs its full length
        state_d = c_st_t3;
        phase_d = '0;
      end else if (phase_last) begin
        case (state_q)
          c_st_t1: state_d = c_st_t2;
          c_st_t2: state_d = c_st_tw;
          c_st_tw: state_d = wait_s ? c_st_tw : c_st_t3;
          default: state_d = c_st_idle;
        endcase
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    logic strobe;
    strobe          = (state_q == c_st_t2) || (state_q == c_st_tw) ||
                      (state_q == c_st_t3);
    bus_ready       = (state_q == c_st_idle);
    p_slot_ioreq_n  = !strobe;
    p_slot_rd_n     = !(strobe && !write_q);
    p_slot_wr_n     = !(strobe && write_q);
    p_slot_data_oe  = (state_q != c_st_idle) && write_q;
    p_slot_data_out = wdata_q;
    p_slot_address  = addr_q;
    bus_rdata       = rdata_q;
    bus_rdata_en    = rdata_en_q;
  end

  // ---------------- request latch and read capture ----------------
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    rdata_en_d = cycle_end && !write_q;
    if (accept) begin
      addr_d  = bus_address;
      wdata_d = bus_wdata;
      write_d = bus_write;
    end
    if (cycle_end && !write_q) rdata_d = tmo_flag ? 8'hFF : p_slot_data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      write_q    <= 1'b0;
      rdata_q    <= 8'h00;
      rdata_en_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      rdata_en_q <= rdata_en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msx_slot_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_msx_slot_master                                            |
// | Purpose  : Self-checking bench for msx_slot_master (T_CLKS=12). Expected |
// |            cycle results are queued when a request is driven and        |
// |            compared when the cycle returns to IDLE. The timeout case is |
// |            built only with MSX_SLOT_MASTER_WAIT_TIMEOUT_EN.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_msx_slot_master;

  localparam int TC  = 12;
  localparam int TMO = 64;

  typedef struct {
    logic       is_read;
    logic [7:0] rdata;
    int         lat;
    logic       tmo;
  } sb_item_t;

  sb_item_t exp_q[$];

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] bus_address;
  logic       bus_ioreq, bus_write, bus_valid, bus_ready;
  logic [7:0] bus_wdata, bus_rdata;
  logic       bus_rdata_en, bus_timeout;
  logic [7:0] p_slot_address, p_slot_data_out, p_slot_data_in;
  logic       p_slot_ioreq_n, p_slot_rd_n, p_slot_wr_n, p_slot_data_oe, p_slot_wait;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  msx_slot_master #(.T_CLKS(TC), .TIMEOUT_CLKS(TMO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus_address     (bus_address),
    .bus_ioreq       (bus_ioreq),
    .bus_write       (bus_write),
    .bus_valid       (bus_valid),
    .bus_ready       (bus_ready),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_rdata_en    (bus_rdata_en),
    .bus_timeout     (bus_timeout),
    .p_slot_address  (p_slot_address),
    .p_slot_ioreq_n  (p_slot_ioreq_n),
    .p_slot_rd_n     (p_slot_rd_n),
    .p_slot_wr_n     (p_slot_wr_n),
    .p_slot_data_out (p_slot_data_out),
    .p_slot_data_oe  (p_slot_data_oe),
    .p_slot_data_in  (p_slot_data_in),
    .p_slot_wait     (p_slot_wait)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One I/O cycle. Outputs are sampled on falling edges; m counts rising
  // edges since the accepting edge. WAIT is high while m < wait_off.
  task automatic run_io(input logic [7:0] addr, input logic wr,
                        input logic [7:0] wd, input logic [7:0] din,
                        input int wait_off, input int exp_lat,
                        input logic exp_tmo);
    sb_item_t e, g;
    int done_m, ready_lo, oe_hi, iorq_lo, rd_lo, wr_lo;
    int addr_bad, dout_bad, en_cnt, en_at, tmo_cnt, tmo_at;
    logic [7:0] obs;
    e.is_read = !wr;
    e.rdata   = exp_tmo ? 8'hFF : din;
    e.lat     = exp_lat;
    e.tmo     = exp_tmo;
    exp_q.push_back(e);
    done_m = -1; ready_lo = 0; oe_hi = 0; iorq_lo = 0; rd_lo = 0; wr_lo = 0;
    addr_bad = 0; dout_bad = 0; en_cnt = 0; en_at = -1; tmo_cnt = 0; tmo_at = -1;
    obs = 8'h00;
    @(negedge clk);
    bus_address = addr; bus_write = wr; bus_wdata = wd; bus_ioreq = 1'b1;
    bus_valid = 1'b1; p_slot_data_in = din; p_slot_wait = (wait_off > 0);
    @(posedge clk);
    for (int m = 0; m < 400; m++) begin
      @(negedge clk);
      if (done_m < 0 && bus_ready) done_m = m;
      if (!bus_ready) begin
        ready_lo++;
        if (p_slot_address != addr) addr_bad++;
        if (wr && p_slot_data_out != wd) dout_bad++;
      end
      if (p_slot_data_oe)  oe_hi++;
      if (!p_slot_ioreq_n) iorq_lo++;
      if (!p_slot_rd_n)    rd_lo++;
      if (!p_slot_wr_n)    wr_lo++;
      if (bus_rdata_en) begin en_cnt++; en_at = m; obs = bus_rdata; end
      if (bus_timeout)  begin tmo_cnt++; tmo_at = m; end
      // a conflicting request held while busy must not disturb the cycle
      if (m == 0) begin bus_address = ~addr; bus_write = ~wr; bus_wdata = ~wd; end
      if (m == 20) bus_valid = 1'b0;
      p_slot_wait = (m < wait_off);
      if (done_m >= 0 && m >= done_m + 2) break;
    end
    p_slot_wait = 1'b0;
    g = exp_q.pop_front();
    if (done_m < 0) begin
      chk("cycle_done", 0, 1);
      return;
    end
    chk("latency",  done_m,   g.lat);
    chk("ready_lo", ready_lo, g.lat);
    chk("oe_hi",    oe_hi,    g.is_read ? 0 : g.lat);
    chk("iorq_lo",  iorq_lo,  g.lat - TC);
    chk("rd_lo",    rd_lo,    g.is_read ? g.lat - TC : 0);
    chk("wr_lo",    wr_lo,    g.is_read ? 0 : g.lat - TC);
    chk("addr_bad", addr_bad, 0);
    chk("dout_bad", dout_bad, 0);
    chk("en_cnt",   en_cnt,   g.is_read ? 1 : 0);
    if (g.is_read) begin
      chk("en_at", en_at, g.lat);
      chk("rdata", obs,   g.rdata);
    end
    chk("tmo_cnt", tmo_cnt, g.tmo ? 1 : 0);
    if (g.tmo) chk("tmo_at", tmo_at, en_at);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset_n = 1'b0;
    bus_address = 8'h00; bus_ioreq = 1'b0; bus_write = 1'b0; bus_valid = 1'b0;
    bus_wdata = 8'h00; p_slot_data_in = 8'h00; p_slot_wait = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus_ready,      1);
    chk("rst_iorq",  p_slot_ioreq_n, 1);
    chk("rst_rd",    p_slot_rd_n,    1);
    chk("rst_wr",    p_slot_wr_n,    1);
    chk("rst_oe",    p_slot_data_oe, 0);
    chk("rst_en",    bus_rdata_en,   0);
    chk("rst_tmo",   bus_timeout,    0);
    chk("rst_addr",  p_slot_address, 0);
    chk("rst_dout",  p_slot_data_out, 0);
    chk("rst_rdata", bus_rdata,      0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_io(8'h99, 1'b1, 8'h8F, 8'h00, 0, 4*TC, 1'b0);   // write
    run_io(8'h98, 1'b0, 8'h00, 8'h5A, 0, 4*TC, 1'b0);   // read
    run_io(8'h3C, 1'b0, 8'h00, 8'hC3, 40, 5*TC, 1'b0);  // one extra TW
    run_io(8'h10, 1'b1, 8'h21, 8'hEE, 0, 4*TC, 1'b0);   // write leaves rdata alone
    chk("rdata_hold", bus_rdata, 8'hC3);

    // ignored request: bus_ioreq low
    bad = 0;
    @(negedge clk);
    bus_address = 8'h55; bus_write = 1'b1; bus_ioreq = 1'b0; bus_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus_ready || !p_slot_ioreq_n || !p_slot_rd_n || !p_slot_wr_n ||
          p_slot_data_oe || bus_rdata_en) bad++;
    end
    bus_valid = 1'b0;
    chk("ign_bad",  bad, 0);
    chk("ign_addr", p_slot_address, 8'h10);

    // reset pulsed during T2 of a write
    @(negedge clk);
    bus_address = 8'h77; bus_write = 1'b1; bus_wdata = 8'hAA; bus_ioreq = 1'b1;
    bus_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_valid = 1'b0;
    repeat (14) @(negedge clk);   // state index 14 = T2
    chk("t2_wr_low", p_slot_wr_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_wr",    p_slot_wr_n,    1);
    chk("arst_iorq",  p_slot_ioreq_n, 1);
    chk("arst_oe",    p_slot_data_oe, 0);
    chk("arst_ready", bus_ready,      1);
    chk("arst_addr",  p_slot_address, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_io(8'h98, 1'b0, 8'h00, 8'h66, 0, 4*TC, 1'b0);

`ifdef MSX_SLOT_MASTER_WAIT_TIMEOUT_EN
    // WAIT stuck high: T1+T2+TW, TMO clocks of extension, then full T3
    run_io(8'hA0, 1'b0, 8'h00, 8'h12, 1000, 4*TC + TMO, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
